// File: rtl/tile_plotter.sv
// Tile plotter: on each accepted event it scans one tile of pixels at the cursor
// position, then advances the cursor over a ROWS x COLS board, column by column.
module tile_plotter #(
    parameter int ROWS   = 5,
    parameter int COLS   = 6,
    parameter int X0     = 28,
    parameter int Y0     = 30,
    parameter int XPITCH = 11,
    parameter int YPITCH = 8,
    parameter int TILE_W = 9,
    parameter int TILE_H = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       evt_valid,
    input  logic [1:0] evt_code,
    output logic       evt_ready,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic       board_full,
    output logic [4:0] cur_row,
    output logic [4:0] cur_col
);

    typedef enum logic [1:0] {IDLE, DRAW, ADVANCE} state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] code_q;
    logic       fill_q;
    logic [3:0] dx;
    logic [3:0] dy;
    logic [3:0] dx_next;
    logic [3:0] dy_next;
    logic       start;
    logic       last_px;

    // Pixel coordinates wrap modulo 256 by truncation of the full-width sum.
    function automatic logic [7:0] pix_x(input logic [4:0] col, input logic [3:0] d);
        return 8'(X0 + int'(col) * XPITCH + int'(d));
    endfunction

    function automatic logic [7:0] pix_y(input logic [4:0] row, input logic [3:0] d);
        return 8'(Y0 + int'(row) * YPITCH + int'(d));
    endfunction

    function automatic logic on_border(input logic [3:0] px, input logic [3:0] py);
        return (px == 4'd0) || (px == 4'(TILE_W - 1)) ||
               (py == 4'd0) || (py == 4'(TILE_H - 1));
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        evt_ready  = 1'b0;
        start      = 1'b0;
        last_px    = (dx == 4'(TILE_W - 1)) && (dy == 4'(TILE_H - 1));
        dx_next    = dx + 4'd1;
        dy_next    = dy;
        if (dx == 4'(TILE_W - 1)) begin
            dx_next = 4'd0;
            dy_next = dy + 4'd1;
        end
        case (state)
            IDLE: begin
                evt_ready = 1'b1;
                // Code 00 and, on a full board, codes 01/10 are consumed silently.
                if (evt_valid && (evt_code == 2'b11 || (evt_code != 2'b00 && !board_full))) begin
                    start      = 1'b1;
                    state_next = DRAW;
                end
            end
            DRAW:    if (last_px) state_next = ADVANCE;
            ADVANCE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            code_q     <= 2'b00;
            fill_q     <= 1'b0;
            dx         <= 4'd0;
            dy         <= 4'd0;
            x          <= 8'd0;
            y          <= 8'd0;
            colour     <= 3'd0;
            plot       <= 1'b0;
            done       <= 1'b0;
            board_full <= 1'b0;
            cur_row    <= 5'd0;
            cur_col    <= 5'd0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The first pixel is registered at acceptance so it appears next cycle.
                    if (start) begin
                        code_q <= evt_code;
                        fill_q <= (evt_code != 2'b11);
                        colour <= (evt_code == 2'b10) ? 3'b100 : 3'b111;
                        dx     <= 4'd0;
                        dy     <= 4'd0;
                        x      <= pix_x(cur_col, 4'd0);
                        y      <= pix_y(cur_row, 4'd0);
                        plot   <= 1'b1;
                    end
                end
                DRAW: begin
                    if (last_px) begin
                        done <= 1'b1;
                    end else begin
                        dx   <= dx_next;
                        dy   <= dy_next;
                        x    <= pix_x(cur_col, dx_next);
                        y    <= pix_y(cur_row, dy_next);
                        plot <= fill_q || on_border(dx_next, dy_next);
                    end
                end
                ADVANCE: begin
                    case (code_q)
                        2'b01: begin
                            if (cur_row < 5'(ROWS - 1)) begin
                                cur_row <= cur_row + 5'd1;
                            end else if (cur_col < 5'(COLS - 1)) begin
                                cur_row <= 5'd0;
                                cur_col <= cur_col + 5'd1;
                            end else begin
                                board_full <= 1'b1;
                            end
                        end
                        2'b10:   cur_row <= 5'd0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_plotter.sv
// Bench for tile_plotter: table of scripted events, hand-written corner sequences,
// and random events checked against a board-level reference model.
module tb_tile_plotter;

    localparam int ROWS = 5, COLS = 6, X0 = 28, Y0 = 30, XPITCH = 11, YPITCH = 8;
    localparam int TILE_W = 9, TILE_H = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       evt_valid = 1'b0;
    logic [1:0] evt_code = 2'b00;
    logic       evt_ready;
    logic [7:0] x, y;
    logic [2:0] colour;
    logic       plot, done, board_full;
    logic [4:0] cur_row, cur_col;

    int total = 0;
    int bad   = 0;

    // reference model of the board
    int m_row, m_col;
    bit m_full;

    tile_plotter dut (
        .clock(clock), .reset(reset), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_ready(evt_ready), .x(x), .y(y), .colour(colour), .plot(plot),
        .done(done), .board_full(board_full), .cur_row(cur_row), .cur_col(cur_col)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] code;
        int         np;
        int         fx, fy, lx, ly;
        logic [2:0] colr;
        int         nd;
        int         row_a, col_a;
        logic       cplot;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        evt_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_state", {evt_ready, plot, done, x, y, colour, board_full, cur_row, cur_col},
              {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 5'd0, 5'd0});
        reset = 1'b0;
        m_row = 0; m_col = 0; m_full = 0;
        @(negedge clock);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!evt_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!evt_ready) check("ready_timeout", {63'd0, evt_ready}, 64'd1);
    endtask

    task automatic model_advance(input logic [1:0] code);
        int idx;
        if (code == 2'b01) begin
            idx = m_col * ROWS + m_row;
            if (idx == ROWS * COLS - 1) m_full = 1;
            else begin
                idx++;
                m_row = idx % ROWS;
                m_col = idx / ROWS;
            end
        end else if (code == 2'b10) begin
            m_row = 0;
        end
    endtask

    // Applies one event and checks every cycle against the model.
    task automatic run_event(input logic [1:0] code, input bit noise);
        bit         draws, fill, ep;
        logic [2:0] col;
        logic [7:0] xe, ye;
        wait_ready();
        draws = (code == 2'b11) || (code != 2'b00 && !m_full);
        fill  = (code != 2'b11);
        col   = (code == 2'b10) ? 3'b100 : 3'b111;
        evt_valid = 1'b1;
        evt_code  = code;
        @(negedge clock);
        evt_valid = 1'b0;
        evt_code  = 2'($urandom);
        if (draws) begin
            for (int dy = 0; dy < TILE_H; dy++) begin
                for (int dx = 0; dx < TILE_W; dx++) begin
                    ep = fill || dx == 0 || dx == TILE_W - 1 || dy == 0 || dy == TILE_H - 1;
                    xe = 8'((X0 + m_col * XPITCH + dx) % 256);
                    ye = 8'((Y0 + m_row * YPITCH + dy) % 256);
                    check("pixel", {plot, done, x, y, colour}, {ep, 1'b0, xe, ye, col});
                    if (noise) begin
                        evt_valid = 1'($urandom);
                        evt_code  = 2'($urandom);
                    end
                    @(negedge clock);
                end
            end
            evt_valid = 1'b0;
            check("done_pulse", {plot, done, evt_ready}, {1'b0, 1'b1, 1'b0});
            model_advance(code);
            @(negedge clock);
        end else begin
            check("no_draw", {plot, done}, 2'b00);
        end
        check("cursor", {evt_ready, board_full, cur_row, cur_col, done},
              {1'b1, m_full, 5'(m_row), 5'(m_col), 1'b0});
    endtask

    // Applies one event and summarises what the DUT produced over 60 cycles.
    task automatic capture(input logic [1:0] code, output int np, output int fx, output int fy,
                           output int lx, output int ly, output logic [2:0] colr,
                           output int nd, output logic cplot);
        wait_ready();
        evt_valid = 1'b1;
        evt_code  = code;
        @(negedge clock);
        evt_valid = 1'b0;
        np = 0; nd = 0; fx = -1; fy = -1; lx = -1; ly = -1; colr = 3'd0; cplot = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (plot) begin
                if (np == 0) begin
                    fx = int'(x); fy = int'(y); colr = colour;
                end
                lx = int'(x); ly = int'(y);
                np++;
            end
            if (done) nd++;
            if (k == 31) cplot = plot;
            @(negedge clock);
        end
    endtask

    initial begin
        int np, fx, fy, lx, ly, nd, stray;
        logic [2:0] colr;
        logic cplot;

        tbl[0]  = '{2'b01, 54, 28, 30, 36, 35, 3'b111, 1, 1, 0, 1'b1};
        tbl[1]  = '{2'b01, 54, 28, 38, 36, 43, 3'b111, 1, 2, 0, 1'b1};
        tbl[2]  = '{2'b01, 54, 28, 46, 36, 51, 3'b111, 1, 3, 0, 1'b1};
        tbl[3]  = '{2'b01, 54, 28, 54, 36, 59, 3'b111, 1, 4, 0, 1'b1};
        tbl[4]  = '{2'b01, 54, 28, 62, 36, 67, 3'b111, 1, 0, 1, 1'b1};
        tbl[5]  = '{2'b01, 54, 39, 30, 47, 35, 3'b111, 1, 1, 1, 1'b1};
        tbl[6]  = '{2'b01, 54, 39, 38, 47, 43, 3'b111, 1, 2, 1, 1'b1};
        tbl[7]  = '{2'b01, 54, 39, 46, 47, 51, 3'b111, 1, 3, 1, 1'b1};
        tbl[8]  = '{2'b10, 54, 39, 54, 47, 59, 3'b100, 1, 0, 1, 1'b1};
        tbl[9]  = '{2'b11, 26, 39, 30, 47, 35, 3'b111, 1, 0, 1, 1'b0};
        tbl[10] = '{2'b00, 0, -1, -1, -1, -1, 3'b000, 0, 0, 1, 1'b0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            capture(tbl[i].code, np, fx, fy, lx, ly, colr, nd, cplot);
            check("tbl_nplots", 64'(np), 64'(tbl[i].np));
            check("tbl_first", {32'(fx), 32'(fy)}, {32'(tbl[i].fx), 32'(tbl[i].fy)});
            check("tbl_last", {32'(lx), 32'(ly)}, {32'(tbl[i].lx), 32'(tbl[i].ly)});
            check("tbl_colour_done", {29'd0, colr, 32'(nd)}, {29'd0, tbl[i].colr, 32'(tbl[i].nd)});
            check("tbl_cursor_centre", {cur_row, cur_col, cplot},
                  {5'(tbl[i].row_a), 5'(tbl[i].col_a), tbl[i].cplot});
        end

        // Fill the whole board, then confirm discard of 01 and drawing of 11.
        do_reset();
        for (int i = 0; i < ROWS * COLS; i++) run_event(2'b01, 1'b1);
        check("full_flag", {board_full, cur_row, cur_col}, {1'b1, 5'd4, 5'd5});
        capture(2'b01, np, fx, fy, lx, ly, colr, nd, cplot);
        check("full_discard", {32'(np), 32'(nd)}, 64'd0);
        capture(2'b11, np, fx, fy, lx, ly, colr, nd, cplot);
        check("full_highlight_pos", {32'(fx), 32'(fy)}, {32'd83, 32'd62});
        check("full_highlight_cnt", {32'(np), 32'(nd)}, {32'd26, 32'd1});
        check("full_after", {board_full, cur_row, cur_col}, {1'b1, 5'd4, 5'd5});

        // Reset in the middle of a tile, with an event pending.
        do_reset();
        run_event(2'b01, 1'b0);
        wait_ready();
        evt_valid = 1'b1;
        evt_code  = 2'b01;
        @(negedge clock);
        evt_valid = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clock);
        reset = 1'b1;
        evt_valid = 1'b1;
        @(negedge clock);
        check("abort_state", {plot, done, x, y, colour, board_full, cur_row, cur_col},
              {1'b0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 5'd0, 5'd0});
        @(negedge clock);
        check("abort_priority", {plot, done, evt_ready}, {1'b0, 1'b0, 1'b1});
        evt_valid = 1'b0;
        reset = 1'b0;
        m_row = 0; m_col = 0; m_full = 0;
        stray = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (plot || done) stray++;
        end
        check("abort_quiet", 64'(stray), 64'd0);
        capture(2'b01, np, fx, fy, lx, ly, colr, nd, cplot);
        check("abort_redraw", {32'(fx), 32'(fy)}, {32'd28, 32'd30});
        check("abort_redraw_cursor", {cur_row, cur_col}, {5'd1, 5'd0});

        // Random events against the model, with busy-time noise and idle gaps.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [1:0] c;
            r = int'($urandom_range(0, 9));
            c = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
            run_event(c, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
